// File: rtl/rv32_pkg.sv
// Opcode and load-funct3 encodings shared by the RV32I pipeline stages.
// Also classifies opcodes by the source of their register-file write value.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LINK,
    WB_SRC_LOAD
  } wb_src_e;

  function automatic wb_src_e wb_src(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: wb_src = WB_SRC_ALU;
      OPC_JAL, OPC_JALR:                      wb_src = WB_SRC_LINK;
      OPC_LOAD:                               wb_src = WB_SRC_LOAD;
      default:                                wb_src = WB_SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a dmemory word and extends it.
// Flags misaligned accesses and reserved load funct3 encodings.
module load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        data  = {{16{half_sel[15]}}, half_sel};
        fault = addr[0];
      end
      F3_LHU: begin
        data  = {16'd0, half_sel};
        fault = addr[0];
      end
      F3_LW: begin
        data  = mem_rdata;
        fault = (addr != 2'd0);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV32I write-back stage: MEM/WB register, load alignment, result mux,
// register-file write port and retired-instruction counter.
module writeback_stage
  import rv32_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          instruction_in,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          alu_res_in,
  input  logic [31:0]          mem_rdata,
  output logic                 rd_we,
  output logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  output logic                 wb_valid,
  output logic                 load_fault,
  output logic [INSTRET_W-1:0] instret
);

  logic                 valid_q, valid_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          alu_res_q, alu_res_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic        ret;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  wb_src_e     src;
  logic [31:0] load_data;
  logic        align_fault;
  logic        fault;
  logic [31:0] wb_data;
  logic        unused_instr_bits;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    alu_res_d = alu_res_q;
    if (flush) begin
      valid_d   = 1'b0;
      instr_d   = instruction_in;
      pc_d      = pc_in;
      alu_res_d = alu_res_in;
    end else if (!stall) begin
      valid_d   = valid_in;
      instr_d   = instruction_in;
      pc_d      = pc_in;
      alu_res_d = alu_res_in;
    end
  end

  // A stalled instruction retires in the cycle the stall releases it.
  assign ret       = valid_q && !stall;
  assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, ret};

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign src    = wb_src(opcode);
  assign unused_instr_bits = ^instr_q[31:15];

  load_align u_load_align (
    .funct3   (funct3),
    .addr     (alu_res_q[1:0]),
    .mem_rdata(mem_rdata),
    .data     (load_data),
    .fault    (align_fault)
  );

  assign fault = (src == WB_SRC_LOAD) && align_fault;

  always_comb begin
    wb_data = '0;
    if (valid_q && !fault) begin
      case (src)
        WB_SRC_ALU:  wb_data = alu_res_q;
        WB_SRC_LINK: wb_data = pc_q + 32'd4;
        WB_SRC_LOAD: wb_data = load_data;
        default:     wb_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      alu_res_q <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      alu_res_q <= alu_res_d;
      instret_q <= instret_d;
    end
  end

  assign rd_we      = ret && (src != WB_SRC_NONE) && (rd != 5'd0) && !fault;
  assign rd_addr    = valid_q ? rd : 5'd0;
  assign rd_data    = wb_data;
  assign wb_valid   = valid_q;
  assign load_fault = valid_q && fault;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed scoreboard bench for writeback_stage against a
// behavioural model of the write-back rules.
module tb_writeback_stage;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic [31:0] alu_res_in;
  logic [31:0] mem_rdata;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wb_valid;
  logic        load_fault;
  logic [63:0] instret;

  writeback_stage #(.INSTRET_W(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .valid_in      (valid_in),
    .stall         (stall),
    .flush         (flush),
    .instruction_in(instruction_in),
    .pc_in         (pc_in),
    .alu_res_in    (alu_res_in),
    .mem_rdata     (mem_rdata),
    .rd_we         (rd_we),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wb_valid      (wb_valid),
    .load_fault    (load_fault),
    .instret       (instret)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          chk;
    bit          chk_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wb_valid;
    logic        load_fault;
    logic [63:0] instret;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    bit          live;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
  } slot_t;

  exp_t        exp_q[$];
  slot_t       m_slot;
  logic [63:0] m_instret;
  bit          m_known;
  int          n_checks;
  int          n_err;

  // Reference behaviour: what the register file should see for the
  // instruction currently sitting in WB.
  function automatic exp_t model_out(input slot_t s, input logic st, input logic [31:0] mem,
                                     input logic [63:0] cnt);
    exp_t        e;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    bit          writes;
    bit          bad;
    logic [31:0] val;
    op     = s.instr[6:0];
    rd     = s.instr[11:7];
    f3     = s.instr[14:12];
    lane   = s.alu[1:0];
    b      = 8'(mem >> (8 * lane));
    h      = 16'(mem >> (16 * lane[1]));
    writes = (op == 7'b0110111) || (op == 7'b0010111) || (op == 7'b0010011) ||
             (op == 7'b0110011) || (op == 7'b1101111) || (op == 7'b1100111) ||
             (op == 7'b0000011);
    bad    = 0;
    val    = s.alu;
    if (op == 7'b1101111 || op == 7'b1100111) val = s.pc + 32'd4;
    if (op == 7'b0000011) begin
      case (f3)
        3'b000: val = {{24{b[7]}}, b};
        3'b100: val = {24'd0, b};
        3'b001: begin val = {{16{h[15]}}, h}; bad = lane[0]; end
        3'b101: begin val = {16'd0, h}; bad = lane[0]; end
        3'b010: begin val = mem; bad = (lane != 0); end
        default: bad = 1;
      endcase
    end
    e.chk        = 1;
    e.rd_we      = s.live && !st && writes && (rd != 0) && !bad;
    e.rd_addr    = s.live ? rd : 5'd0;
    e.rd_data    = (s.live && writes && !bad) ? val : 32'd0;
    e.wb_valid   = s.live;
    e.load_fault = s.live && bad;
    e.instret    = cnt;
    e.chk_data   = e.rd_we || e.load_fault || !s.live;
    e.pc         = s.pc;
    return e;
  endfunction

  task automatic cycle(input logic rst_n, input logic vin, input logic st, input logic fl,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input bit preload = 0);
    exp_t e;
    @(negedge clock);
    if (preload) begin
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    reset          = rst_n;
    valid_in       = vin;
    stall          = st;
    flush          = fl;
    instruction_in = ins;
    pc_in          = pc;
    alu_res_in     = alu;
    mem_rdata      = mem;
    #1;
    e     = model_out(m_slot, st, mem, m_instret);
    e.chk = m_known;
    exp_q.push_back(e);
    if (!rst_n) begin
      m_slot    = '{live: 0, instr: 32'd0, pc: 32'd0, alu: 32'd0};
      m_instret = 64'd0;
      m_known   = 1;
    end else if (m_known) begin
      if (m_slot.live && !st) m_instret = m_instret + 64'd1;
      if (fl) m_slot.live = 0;
      else if (!st) m_slot = '{live: vin, instr: ins, pc: pc, alu: alu};
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("rd_we", 64'(rd_we), 64'(e.rd_we));
          check("rd_addr", 64'(rd_addr), 64'(e.rd_addr));
          check("wb_valid", 64'(wb_valid), 64'(e.wb_valid));
          check("load_fault", 64'(load_fault), 64'(e.load_fault));
          check("instret", instret, e.instret);
          if (e.chk_data) check("rd_data", 64'(rd_data), 64'(e.rd_data));
          if (e.rd_we || e.load_fault)
            $display("t=%0t wb pc=%h rd=%0d data=%h fault=%b instret=%0d",
                     $time, e.pc, e.rd_addr, e.rd_data, e.load_fault, e.instret);
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  localparam logic [31:0] ADD_X5 = 32'h002082B3;
  localparam logic [31:0] WORD   = 32'h12F45678;

  initial begin
    logic [6:0]  ops [11];
    logic [6:0]  op;
    logic [4:0]  rd;
    n_checks  = 0;
    n_err     = 0;
    m_known   = 0;
    m_instret = 64'd0;
    m_slot    = '{live: 0, instr: 32'd0, pc: 32'd0, alu: 32'd0};
    reset = 0; valid_in = 0; stall = 0; flush = 0;
    instruction_in = 0; pc_in = 0; alu_res_in = 0; mem_rdata = 0;
    ops = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111,
            7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0001111};

    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, ADD_X5, 32'h100, 32'h7, 0);
    cycle(1, 1, 0, 0, enc(7'b0000011, 6, 3'b000), 32'h104, 32'h1002, 0);
    cycle(1, 1, 0, 0, enc(7'b0000011, 7, 3'b100), 32'h108, 32'h1002, WORD);
    cycle(1, 1, 0, 0, enc(7'b0000011, 8, 3'b101), 32'h10C, 32'h1002, WORD);
    cycle(1, 1, 0, 0, enc(7'b0000011, 9, 3'b010), 32'h110, 32'h1002, WORD);
    cycle(1, 1, 0, 0, enc(7'b0000011, 10, 3'b001), 32'h114, 32'h1001, WORD);
    cycle(1, 1, 0, 0, enc(7'b0000011, 11, 3'b011), 32'h118, 32'h1000, WORD);
    cycle(1, 1, 0, 0, enc(7'b1101111, 1, 3'b000), 32'hFFFFFFFC, 32'h55, WORD);
    cycle(1, 1, 0, 0, enc(7'b0010011, 0, 3'b000), 32'h11C, 32'h99, 0);
    cycle(1, 1, 0, 0, enc(7'b0100011, 4, 3'b010), 32'h120, 32'h2000, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // stalled load retires once
    cycle(1, 1, 0, 0, enc(7'b0000011, 12, 3'b000), 32'h200, 32'h1003, 0);
    cycle(1, 1, 1, 0, ADD_X5, 32'h204, 32'h1, WORD);
    cycle(1, 1, 1, 0, ADD_X5, 32'h204, 32'h1, WORD);
    cycle(1, 1, 1, 0, ADD_X5, 32'h204, 32'h1, WORD);
    cycle(1, 0, 0, 0, 0, 0, 0, WORD);
    cycle(1, 1, 1, 1, ADD_X5, 32'h208, 32'h2, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // counter wrap
    cycle(1, 1, 0, 0, ADD_X5, 32'h300, 32'h3, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    // reset during a held stall
    cycle(1, 1, 0, 0, ADD_X5, 32'h400, 32'h4, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 10)];
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            {$urandom} & 32'hFFFF8000 | 32'(enc(op, rd, 3'($urandom))),
            $urandom & 32'hFFFFFFFC, $urandom, $urandom);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core, directly downstream of the memory stage.
- Registers the memory stage's instruction, PC and ALU result into a MEM/WB pipeline register.
- Aligns and extends the load data returned by dmemory, selects the register-file write value, and drives the register-file write port.
- Maintains a retired-instruction counter and flags misaligned or illegal loads.

Parameters:
INSTRET_W, 64, width of the retired-instruction counter (wraps modulo 2^INSTRET_W).

Ports:
clock  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-low
valid_in  input  1  memory stage holds a live instruction
stall  input  1  hazard unit freeze; WB register holds its contents
flush  input  1  kill the instruction being captured this edge
instruction_in  input  32  instruction from the memory stage
pc_in  input  32  PC of that instruction
alu_res_in  input  32  ALU result / effective address from the memory stage
mem_rdata  input  32  dmemory read word; valid in the cycle the load occupies WB (registered dmemory read)
rd_we  output  1  register-file write enable
rd_addr  output  5  destination register
rd_data  output  32  write-back value
wb_valid  output  1  WB register holds a live instruction
load_fault  output  1  misaligned or illegal-funct3 load in WB
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset (reset==0 at a clock edge) has priority over all other inputs. It clears the WB register: valid=0, instruction=0, pc=0, alu_res=0, and sets instret=0.
  - After reset: rd_we=0, rd_addr=0, rd_data=0, wb_valid=0, load_fault=0, instret=0.
- Capture rules at each rising edge with reset==1:
  - flush=1: valid<=0; flush beats stall.
  - else stall=1: all WB fields hold; instret holds.
  - else: valid<=valid_in; instruction, pc and alu_res are captured unconditionally.
- Retire condition: ret = wb_valid && !stall. It is evaluated in the WB cycle, so an instruction held by stall retires exactly once, in the cycle stall drops.
- Decode uses opcode = instruction[6:0], rd = instruction[11:7], funct3 = instruction[14:12].
- Writing opcodes and their rd_data source:
  - LUI 0110111, AUIPC 0010111, OP-IMM 0010011, OP 0110011: rd_data = alu_res.
  - JAL 1101111, JALR 1100111: rd_data = pc + 4, 32-bit wrap.
  - LOAD 0000011: rd_data = aligned load value.
  - All other opcodes (STORE, BRANCH, FENCE, SYSTEM, unknown) do not write.
- Load alignment: byte lane is alu_res[1:0]; halfword lane is alu_res[1].
  - LB 000: sign-extend the selected byte.
  - LBU 100: zero-extend the selected byte.
  - LH 001: sign-extend the selected halfword.
  - LHU 101: zero-extend the selected halfword.
  - LW 010: whole word.
- Load faults:
  - Misaligned: halfword with alu_res[0]=1, or LW with alu_res[1:0]!=0.
  - Illegal: funct3 in {011, 110, 111}.
  - On a fault: load_fault=wb_valid, rd_we=0, rd_data=0. The instruction still retires (counts in instret).
- rd_we = ret && writing opcode && rd!=0 && !fault.
- rd_addr = rd whenever wb_valid, else 0.
- rd_data is combinational from the WB register and mem_rdata; it is 0 when the instruction does not write.
- instret increments by 1 on each edge where ret=1 and reset==1, and wraps from all-ones to 0.
- Latency: an instruction presented with valid_in at edge N is written to the register file at edge N+1, assuming no stall.
- Reset asserted mid-stall discards the held instruction without a write.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants: OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Shared with decode, execute and memory stages.
- Sub-module load_align: combinational. Takes funct3, addr[1:0] and mem_rdata; produces the aligned data and a fault bit.
- Top level holds the pipeline register, write-enable logic, result mux and counter.

Test Plan:
- ADD x5 (instr 0x002081B3 with rd=5, i.e. 0x002082B3), alu_res_in=0x00000007, valid_in=1 -> one cycle later rd_we=1, rd_addr=5, rd_data=0x00000007, instret=1.
- LB x6, alu_res_in=0x00001002, mem_rdata=0x12F45678 -> rd_data=0xFFFFFFF4. Same word with LBU -> 0x000000F4. LHU at addr 0x...2 -> 0x000012F4.
- LW with alu_res_in=0x00001002 -> load_fault=1, rd_we=0, rd_data=0, instret still increments. LH at 0x...1 and funct3=011 also fault.
- JAL rd=1 at pc_in=0xFFFFFFFC -> rd_data=0x00000000 (wrap), rd_we=1. ADDI with rd=0 -> rd_we=0; SW -> rd_we=0, instret+1.
- Load captured, then stall held 3 cycles -> rd_we stays 0 during stall and pulses once when stall drops; instret +1 total. flush and stall together at capture -> wb_valid=0 next cycle.
- Preload instret to all-ones by forcing, retire one instruction -> instret=0. Assert reset=0 during a held stall -> no write, all outputs 0 the next cycle.
